// File: rtl/nlfsr_farm_scheduler.sv
// nlfsr_farm_scheduler
//   Dispatches tap-coefficient sets to an array of NLFSR search workers and
//   collects their results.
//   - in_*      : coefficient stream. A set is accepted into the lowest-index
//                 idle slot.
//   - co_buf/wrk_res/ena : per-worker coefficients, reset pulse and enable.
//   - found/failure      : per-worker result levels.
//   - out_*     : first-word-fall-through FIFO of found results
//                 (worker index and coefficients).
//   - found_any, tested_cnt, found_cnt : statistics. clr zeroes them.
//   - busy      : any slot in use, or a result is still pending.

// Per-worker slot: IDLE -> LOAD -> RUN -> FAIL/FOUND -> IDLE.
module nlfsr_slot #(
  parameter int COEF_W = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,      // this slot takes the offered set
  input  logic [COEF_W-1:0] coef_in,
  input  logic              found,
  input  logic              failure,
  input  logic              push_grant, // this slot's result enters the FIFO
  output logic [COEF_W-1:0] coef,
  output logic              wrk_res,
  output logic              ena,
  output logic              idle,
  output logic              is_found,
  output logic              retire      // entering FAIL or FOUND this cycle
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FAIL, S_FOUND} slot_state_e;

  slot_state_e       state_q, state_d;
  logic [COEF_W-1:0] coef_q, coef_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      coef_q  <= '0;
    end else begin
      state_q <= state_d;
      coef_q  <= coef_d;
    end
  end

  // found/failure are only sampled in RUN, so levels left over from the
  // previous job are ignored while the worker is being reloaded.
  always_comb begin
    state_d = state_q;
    coef_d  = coef_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:  if (alloc) begin
                 state_d = S_LOAD;
                 coef_d  = coef_in;
               end
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (found) begin
                 state_d = S_FOUND;
                 retire  = 1'b1;
               end else if (failure) begin
                 state_d = S_FAIL;
                 retire  = 1'b1;
               end
      S_FAIL:  state_d = S_IDLE;
      S_FOUND: if (push_grant) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign coef     = coef_q;
  assign wrk_res  = (state_q == S_LOAD);
  assign ena      = (state_q == S_RUN);
  assign idle     = (state_q == S_IDLE);
  assign is_found = (state_q == S_FOUND);
endmodule

module nlfsr_farm_scheduler #(
  parameter  int NUM_OF_TAPS    = 6,
  parameter  int NUM_OF_MODULES = 30,
  parameter  int FIFO_DEPTH     = 8,
  parameter  int CNT_W          = 32,
  localparam int COEF_W         = NUM_OF_TAPS * 8,
  localparam int IDX_W          = (NUM_OF_MODULES > 1) ? $clog2(NUM_OF_MODULES) : 1
) (
  input  logic                             clk,
  input  logic                             res,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [COEF_W-1:0]                in_coef,
  output logic [NUM_OF_MODULES*COEF_W-1:0] co_buf,
  output logic [NUM_OF_MODULES-1:0]        wrk_res,
  output logic [NUM_OF_MODULES-1:0]        ena,
  input  logic [NUM_OF_MODULES-1:0]        found,
  input  logic [NUM_OF_MODULES-1:0]        failure,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [IDX_W-1:0]                 out_idx,
  output logic [COEF_W-1:0]                out_coef,
  output logic                             found_any,
  input  logic                             clr,
  output logic [CNT_W-1:0]                 tested_cnt,
  output logic [CNT_W-1:0]                 found_cnt,
  output logic                             busy
);
  localparam int N     = NUM_OF_MODULES;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [COEF_W-1:0] coef;
  } res_entry_t;

  logic [N-1:0]             idle, is_found, retire, alloc, found_low, grant;
  logic [N-1:0][COEF_W-1:0] slot_coef;
  logic                     accept, push, pop, full, empty;
  res_entry_t               push_entry;

  // ---------------- slots ----------------
  for (genvar g = 0; g < N; g++) begin : g_slot
    nlfsr_slot #(.COEF_W(COEF_W)) u_slot (
      .clk        (clk),
      .rst        (res),
      .alloc      (alloc[g]),
      .coef_in    (in_coef),
      .found      (found[g]),
      .failure    (failure[g]),
      .push_grant (grant[g]),
      .coef       (slot_coef[g]),
      .wrk_res    (wrk_res[g]),
      .ena        (ena[g]),
      .idle       (idle[g]),
      .is_found   (is_found[g]),
      .retire     (retire[g])
    );
  end

  // Packed array flattens with slot 0 in the low bits.
  assign co_buf = slot_coef;

  // Allocation only sees registered IDLE, so a slot freed on an edge is
  // offered from the following cycle.
  assign in_ready = |idle;
  assign accept   = in_valid & in_ready;
  // x & -x isolates the lowest set bit.
  assign alloc    = accept ? (idle & (~idle + N'(1))) : '0;

  // ---------------- retirement into the FIFO ----------------
  assign found_low = is_found & (~is_found + N'(1));
  assign pop       = out_valid & out_ready;
  assign push      = (|is_found) & (~full | pop);
  assign grant     = push ? found_low : '0;

  always_comb begin
    push_entry = '0;
    for (int i = 0; i < N; i++) begin
      if (found_low[i]) begin
        push_entry.idx  = IDX_W'(i);
        push_entry.coef = slot_coef[i];
      end
    end
  end

  // ---------------- result FIFO ----------------
  // Pointers carry one extra bit to tell full from empty.
  res_entry_t       mem_q [FIFO_DEPTH];
  res_entry_t       mem_d [FIFO_DEPTH];
  logic [PTR_W:0]   wr_q, wr_d, rd_q, rd_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                 (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q[PTR_W-1:0]] = push_entry;
      wr_d = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

  assign out_valid = ~empty;
  assign out_idx   = mem_q[rd_q[PTR_W-1:0]].idx;
  assign out_coef  = mem_q[rd_q[PTR_W-1:0]].coef;

  // ---------------- statistics ----------------
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] tested_q, tested_d, found_cnt_q, found_cnt_d;
  logic             found_any_q, found_any_d;

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < N; i++) retire_cnt = retire_cnt + CNT_W'(retire[i]);
  end

  // clr overrides any same-cycle increment.
  always_comb begin
    tested_d    = clr ? '0   : tested_q + retire_cnt;
    found_cnt_d = clr ? '0   : found_cnt_q + CNT_W'(push);
    found_any_d = clr ? 1'b0 : (found_any_q | push);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      tested_q    <= '0;
      found_cnt_q <= '0;
      found_any_q <= 1'b0;
    end else begin
      tested_q    <= tested_d;
      found_cnt_q <= found_cnt_d;
      found_any_q <= found_any_d;
    end
  end

  assign tested_cnt = tested_q;
  assign found_cnt  = found_cnt_q;
  assign found_any  = found_any_q;
  assign busy       = ~(&idle) | ~empty;
endmodule

// File: tb/tb_nlfsr_farm_scheduler.sv
module tb_nlfsr_farm_scheduler;
  localparam int TAPS = 6;
  localparam int N    = 4;
  localparam int FD   = 2;
  localparam int CW   = 32;
  localparam int COEF_W = TAPS * 8;
  localparam int IDX_W  = 2;

  localparam logic [47:0] CA = 48'hA1A2_A3A4_A5A6;
  localparam logic [47:0] CB = 48'hB1B2_B3B4_B5B6;
  localparam logic [47:0] CC = 48'hC1C2_C3C4_C5C6;
  localparam logic [47:0] CD = 48'hD1D2_D3D4_D5D6;
  localparam logic [47:0] CE = 48'hE1E2_E3E4_E5E6;
  localparam logic [47:0] CF = 48'hF1F2_F3F4_F5F6;
  localparam logic [47:0] CG = 48'h1112_1314_1516;
  localparam logic [47:0] CH = 48'h2122_2324_2526;

  logic                clk, res, in_valid, in_ready, out_valid, out_ready;
  logic [COEF_W-1:0]   in_coef, out_coef;
  logic [N*COEF_W-1:0] co_buf;
  logic [N-1:0]        wrk_res, ena, found, failure;
  logic [IDX_W-1:0]    out_idx;
  logic                found_any, clr, busy;
  logic [CW-1:0]       tested_cnt, found_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  nlfsr_farm_scheduler #(
    .NUM_OF_TAPS(TAPS), .NUM_OF_MODULES(N), .FIFO_DEPTH(FD), .CNT_W(CW)
  ) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
    .in_coef(in_coef), .co_buf(co_buf), .wrk_res(wrk_res), .ena(ena),
    .found(found), .failure(failure), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_coef(out_coef),
    .found_any(found_any), .clr(clr), .tested_cnt(tested_cnt),
    .found_cnt(found_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] slot(input int k);
    return co_buf[k*COEF_W +: COEF_W];
  endfunction

  initial begin
    res = 1'b1; in_valid = 0; in_coef = '0; found = '0; failure = '0;
    out_ready = 0; clr = 0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ena", ena, 0);
    chk("rst_wrk_res", wrk_res, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_found_any", found_any, 0);
    chk("rst_tested", tested_cnt, 0);
    chk("rst_found_cnt", found_cnt, 0);
    chk("rst_co_buf", (co_buf == '0), 1);
    res = 1'b0;
    tick();

    // ---- back-to-back loads A..D ----
    in_valid = 1; in_coef = CA;
    tick();
    chk("ld0_wrk_res", wrk_res, 4'b0001);
    chk("ld0_ena", ena, 4'b0000);
    in_coef = CB;
    tick();
    chk("ld1_wrk_res", wrk_res, 4'b0010);
    chk("ld1_ena", ena, 4'b0001);
    in_coef = CC;
    tick();
    chk("ld2_wrk_res", wrk_res, 4'b0100);
    chk("ld2_ena", ena, 4'b0011);
    in_coef = CD;
    tick();
    in_valid = 0;
    chk("ld3_wrk_res", wrk_res, 4'b1000);
    chk("ld3_ena", ena, 4'b0111);
    chk("ld3_in_ready", in_ready, 0);
    tick();
    chk("run_all_ena", ena, 4'b1111);
    chk("run_all_wrk_res", wrk_res, 0);
    chk("cobuf0", slot(0), CA);
    chk("cobuf1", slot(1), CB);
    chk("cobuf2", slot(2), CC);
    chk("cobuf3", slot(3), CD);

    // ---- slot 2 fails, slots 1 and 3 find together ----
    failure[2] = 1; found[1] = 1; found[3] = 1;
    tick();
    chk("ret_tested", tested_cnt, 3);
    chk("ret_ena", ena, 4'b0001);
    chk("ret_in_ready", in_ready, 0);
    chk("ret_out_valid", out_valid, 0);
    tick();
    chk("push1_valid", out_valid, 1);
    chk("push1_idx", out_idx, 1);
    chk("push1_coef", out_coef, CB);
    chk("push1_found_cnt", found_cnt, 1);
    chk("push1_found_any", found_any, 1);
    chk("fail_freed_in_ready", in_ready, 1);
    tick();
    chk("push3_found_cnt", found_cnt, 2);
    chk("push3_head_idx", out_idx, 1);
    out_ready = 1;
    tick();
    chk("pop1_idx", out_idx, 3);
    chk("pop1_coef", out_coef, CD);
    tick();
    out_ready = 0;
    chk("pop2_empty", out_valid, 0);
    chk("idle_stale_tested", tested_cnt, 3);

    // ---- stale found[1] during LOAD is ignored ----
    failure[2] = 0; found[3] = 0;           // found[1] still high (stale)
    in_valid = 1; in_coef = CE;
    tick();
    chk("stale_ld_wrk_res", wrk_res, 4'b0010);
    in_coef = CF;
    tick();                                 // LOAD->RUN edge sees found[1]=1
    chk("stale_run_ena", ena, 4'b0011);
    chk("stale_tested", tested_cnt, 3);
    found[1] = 0;
    in_coef = CG;
    tick();
    in_valid = 0;
    chk("stale_still_run", ena, 4'b0111);
    chk("full_in_ready", in_ready, 0);
    tick();
    chk("stale_all_ena", ena, 4'b1111);
    chk("stale_cobuf1", slot(1), CE);
    chk("stale_tested2", tested_cnt, 3);

    // ---- slot 0 frees while input is waiting ----
    failure[0] = 1; in_valid = 1; in_coef = CH;
    tick();
    chk("free_fail_in_ready", in_ready, 0);
    chk("free_fail_ena", ena, 4'b1110);
    chk("free_tested", tested_cnt, 4);
    tick();
    chk("free_idle_in_ready", in_ready, 1);
    chk("free_no_early_accept", wrk_res, 0);
    tick();
    in_valid = 0; failure[0] = 0;
    chk("refill_wrk_res", wrk_res, 4'b0001);
    chk("refill_cobuf0", slot(0), CH);
    tick();
    chk("refill_ena", ena, 4'b1111);

    // ---- FIFO full: third finder is held ----
    found[3:1] = 3'b111;
    tick();
    found[2:1] = 2'b00;
    chk("hold_tested", tested_cnt, 7);
    chk("hold_ena", ena, 4'b0001);
    tick(); tick(); tick();
    chk("hold_found_cnt", found_cnt, 4);
    chk("hold_head_idx", out_idx, 1);
    chk("hold_ena2", ena, 4'b0001);
    chk("hold_cobuf3", slot(3), CG);
    in_valid = 1; in_coef = CA;
    tick();
    in_coef = CB;
    tick();
    in_valid = 0;
    chk("hold_not_realloc", in_ready, 0);
    chk("hold_cobuf3b", slot(3), CG);
    out_ready = 1;
    tick();
    out_ready = 0; found[3] = 0;
    chk("hold_pop_idx", out_idx, 2);
    chk("hold_pop_coef", out_coef, CF);
    chk("hold_pop_found_cnt", found_cnt, 5);
    chk("hold_slot_idle", in_ready, 1);
    tick();
    chk("hold_fifo_still", out_valid, 1);

    // ---- async reset mid-job ----
    #2 res = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_ena", ena, 0);
    chk("arst_busy", busy, 0);
    chk("arst_found_cnt", found_cnt, 0);
    chk("arst_tested", tested_cnt, 0);
    chk("arst_found_any", found_any, 0);
    chk("arst_co_buf", (co_buf == '0), 1);
    tick();
    res = 0;
    tick();
    chk("arst_in_ready", in_ready, 1);

    // ---- clr coincides with a push ----
    in_valid = 1; in_coef = CC;
    tick();
    in_valid = 0;
    tick();
    found[0] = 1;
    tick();
    chk("clr_pre_tested", tested_cnt, 1);
    clr = 1;
    tick();
    clr = 0; found[0] = 0;
    chk("clr_found_any", found_any, 0);
    chk("clr_found_cnt", found_cnt, 0);
    chk("clr_tested", tested_cnt, 0);
    chk("clr_entry_valid", out_valid, 1);
    chk("clr_entry_idx", out_idx, 0);
    chk("clr_entry_coef", out_coef, CC);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nlfsr_farm_scheduler.md
Name: nlfsr_farm_scheduler

Overview:
- Dispatcher and collector between the UART command interface and a parametrised array of NLFSR search workers.
- Accepts a stream of tap-coefficient sets and issues each to the lowest-numbered idle worker (load, reset pulse, enable).
- Retires workers on found/failure and queues found results (worker index plus coefficients) in a FIFO for read-back.
- Keeps a sticky found flag and tested/found counters, replacing the fixed-array glue of the previous generation.

Parameters:
- NUM_OF_TAPS, 6, taps per coefficient set; COEF_W = NUM_OF_TAPS*8.
- NUM_OF_MODULES, 30, number of worker slots; IDX_W = max(1, clog2(NUM_OF_MODULES)).
- FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2).
- CNT_W, 32, width of the tested and found counters.

Ports:
- clk  in  1  system clock.
- res  in  1  reset, asynchronous, active-high.
- in_valid  in  1  coefficient set offered.
- in_ready  out  1  at least one slot IDLE (decoded from registered state).
- in_coef  in  COEF_W  coefficient set.
- co_buf  out  NUM_OF_MODULES*COEF_W  per-slot coefficients; slot i occupies bits [(i+1)*COEF_W-1 -: COEF_W].
- wrk_res  out  NUM_OF_MODULES  per-worker reset pulse.
- ena  out  NUM_OF_MODULES  per-worker enable.
- found  in  NUM_OF_MODULES  worker level; held until the next wrk_res.
- failure  in  NUM_OF_MODULES  worker level; held until the next wrk_res.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer pops the head.
- out_idx  out  IDX_W  head entry: worker index.
- out_coef  out  COEF_W  head entry: coefficients.
- found_any  out  1  sticky: a found has been recorded.
- clr  in  1  synchronous clear of found_any and both counters.
- tested_cnt  out  CNT_W  count of retired jobs (found or failure).
- found_cnt  out  CNT_W  count of found results pushed to the FIFO.
- busy  out  1  any slot not IDLE, or FIFO not empty.

Behaviour:
- Reset values (asynchronous): all slots IDLE; co_buf=0; wrk_res=0; ena=0; FIFO empty; out_valid=0; found_any=0; both counters 0; busy=0; in_ready=1.
- Per-slot state machine:
  - IDLE -> LOAD on accept.
  - LOAD -> RUN after 1 cycle.
  - RUN -> FAIL if failure[i]=1; RUN -> FOUND if found[i]=1 (found wins when both are 1).
  - FAIL -> IDLE after 1 cycle.
  - FOUND -> IDLE when the slot's entry is pushed to the FIFO.
- Accept: in_valid && in_ready at edge t latches in_coef into the co_buf slice of the lowest-index IDLE slot.
  - wrk_res[i]=1 during cycle t+1 (LOAD) only.
  - ena[i]=1 from cycle t+2 (RUN).
- ena[i] is 1 only in RUN; it drops on the edge where found or failure is sampled.
  - found/failure are ignored in IDLE and LOAD, so stale levels from the previous job are discarded.
- Retirement:
  - All FAIL slots free in parallel.
  - At most one FIFO push per cycle: the lowest-index FOUND slot, pushed only when the FIFO is not full or a pop occurs in the same cycle.
  - Other FOUND slots wait with ena=0 and co_buf retained.
- A slot freed on edge t becomes allocatable from cycle t+1. in_ready never reflects same-cycle frees.
- FIFO:
  - out_* shows the head (first-word fall-through).
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle is legal at any occupancy, including full.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - tested_cnt increments by the number of slots entering FAIL or FOUND this cycle (0..NUM_OF_MODULES).
  - found_cnt increments by 1 per push.
  - Both wrap modulo 2^CNT_W.
- found_any is set on any push.
- clr:
  - Zeros found_any and both counters.
  - If clr coincides with an increment or a push, clr wins for that cycle.
  - clr does not touch slots or the FIFO.
- Reset mid-job aborts everything: slot contents and FIFO entries are lost. No wrk_res pulse is generated by reset; the workers share res.

Test Plan:
- NUM_OF_MODULES=4, push 4 sets A..D on back-to-back cycles -> slots 0..3 loaded in order; in_ready=0 after the 4th accept; wrk_res[k] high exactly 1 cycle, ena[k] high 2 cycles after the accept.
- Slot 2 raises failure while slots 1 and 3 raise found in the same cycle -> slot 2 frees next cycle; FIFO receives idx 1 then idx 3 on consecutive cycles; tested_cnt+=3, found_cnt=2, found_any=1.
- FIFO_DEPTH=2, out_ready=0, three slots find -> 2 entries stored; 3rd slot held with ena=0, not reallocatable; a single pop -> held entry pushed on the same edge as the pop, slot IDLE the cycle after.
- Slot 0 frees while in_valid=1 and all other slots busy -> accept occurs one cycle after the free, into slot 0, with new co_buf and a wrk_res pulse.
- Stale found[1]=1 still asserted during LOAD of a new job -> ignored; the job runs until found re-evaluates in RUN.
- Assert res during RUN with 2 FIFO entries -> all outputs return to reset values immediately (asynchronously); in_ready=1 after release; clr together with a push -> found_any=0, found_cnt=0, entry still stored.
